// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle on operand magnitudes.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             pipe_stall,
    output logic             stallreq,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opnd_a;
    logic [WIDTH-1:0]   opnd_b;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res;
    logic               neg_rem;

    logic               start;
    logic               is_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic               last;

    always_comb begin
        start     = (state == StIdle) && op_valid && !op[2];
        is_signed = !op[0];
        sign_a    = is_signed && src_a[WIDTH-1];
        sign_b    = is_signed && src_b[WIDTH-1];
        abs_a     = sign_a ? (~src_a + 1'b1) : src_a;
        abs_b     = sign_b ? (~src_b + 1'b1) : src_b;

        stallreq  = start || (state == StMul) || (state == StDiv);
        done      = (state == StDone);
        last      = (count == CW'(WIDTH - 1));

        // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opnd_b[0] ? {1'b0, opnd_a} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};

        // Divide: acc holds {remainder, dividend/quotient}; trial-subtract the divisor.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b0, opnd_b};
        div_next  = div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fixed = neg_res ? (~mul_next + 1'b1) : mul_next;
        quot_fixed = neg_res ? (~div_next[WIDTH-1:0] + 1'b1) : div_next[WIDTH-1:0];
        rem_fixed  = neg_rem ? (~div_next[2*WIDTH-1:WIDTH] + 1'b1)
                             : div_next[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            count   <= '0;
            opnd_a  <= '0;
            opnd_b  <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (op_valid && !pipe_stall) begin
                        if (start) begin
                            opnd_a  <= abs_a;
                            opnd_b  <= abs_b;
                            neg_res <= sign_a ^ sign_b;
                            neg_rem <= sign_a;
                            count   <= '0;
                            if (op[1]) begin
                                acc   <= {{WIDTH{1'b0}}, abs_a};
                                state <= StDiv;
                            end else begin
                                acc   <= '0;
                                state <= StMul;
                            end
                        end else if (op == 3'd4) begin
                            hi <= src_a;
                        end else if (op == 3'd5) begin
                            lo <= src_a;
                        end
                    end
                end
                StMul: begin
                    acc    <= mul_next;
                    opnd_b <= opnd_b >> 1;
                    count  <= count + 1'b1;
                    if (last) begin
                        {hi, lo} <= prod_fixed;
                        state    <= StDone;
                    end
                end
                StDiv: begin
                    acc   <= div_next;
                    count <= count + 1'b1;
                    if (last) begin
                        hi    <= rem_fixed;
                        lo    <= quot_fixed;
                        state <= StDone;
                    end
                end
                StDone: begin
                    // Held instruction still sits in EX while stalled; never restart from here.
                    if (!pipe_stall) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: arithmetic reference model compared every cycle,
// plus directed cases with hand-computed results.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        pipe_stall = 1'b0;
    logic        stallreq;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .pipe_stall (pipe_stall),
        .stallreq   (stallreq),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // {hi, lo} an instruction must leave behind.
    function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        logic        sa, sb;
        longint      p;
        if (o == 3'd0) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        if (o == 3'd1) return {32'd0, a} * {32'd0, b};
        sa = (o == 3'd2) && a[31];
        sb = (o == 3'd2) && b[31];
        ua = sa ? (~a + 32'd1) : a;
        ub = sb ? (~b + 32'd1) : b;
        if (ub == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (sa ^ sb) q = ~q + 32'd1;
        if (sa) r = ~r + 32'd1;
        return {r, q};
    endfunction

    // Behavioural timing model: an accepted muldiv op keeps the unit busy for 32 more cycles.
    int          busy_left = 0;
    bit          in_done   = 1'b0;
    logic [31:0] m_hi      = 32'd0;
    logic [31:0] m_lo      = 32'd0;
    logic [63:0] pend      = 64'd0;

    always @(posedge clk) begin
        if (rst) begin
            busy_left = 0;
            in_done   = 1'b0;
            m_hi      = 32'd0;
            m_lo      = 32'd0;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) begin
                {m_hi, m_lo} = pend;
                in_done      = 1'b1;
            end
        end else if (in_done) begin
            if (!pipe_stall) in_done = 1'b0;
        end else if (op_valid && !pipe_stall) begin
            if (op < 3'd4) begin
                pend      = model_result(op, src_a, src_b);
                busy_left = 32;
            end else if (op == 3'd4) begin
                m_hi = src_a;
            end else if (op == 3'd5) begin
                m_lo = src_a;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        if (checking) begin
            exp_stall = (busy_left > 0) || (!in_done && op_valid && (op < 3'd4));
            n_checks++;
            if (stallreq !== exp_stall || done !== in_done || hi !== m_hi || lo !== m_lo) begin
                n_fail++;
                $display("FAIL cycle t=%0t stallreq=%b exp %b done=%b exp %b hi=%h exp %h lo=%h exp %h",
                         $time, stallreq, exp_stall, done, in_done, hi, m_hi, lo, m_lo);
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the edge on which the op leaves EX.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit rnd_stall, output int stall_cycles, output int done_cycles);
        bit fin = 1'b0;
        op_valid     = 1'b1;
        op           = o;
        src_a        = a;
        src_b        = b;
        stall_cycles = 0;
        done_cycles  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (stallreq) stall_cycles++;
            if (done) done_cycles++;
            fin = (o < 3'd4) ? (done && !pipe_stall) : !pipe_stall;
            @(posedge clk);
            #1;
            if (fin) break;
            if (rnd_stall) pipe_stall = ($urandom_range(0, 3) == 0);
        end
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL completion op=%0d: got no completion expected done within 300 cycles", o);
        end
        op_valid   = 1'b0;
        pipe_stall = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int sc, dc, dcount;
        bit seen;
        @(posedge clk);
        #1;
        checking = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check32("reset_stallreq", {31'd0, stallreq}, 32'd0);
        check32("reset_done", {31'd0, done}, 32'd0);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, sc, dc);
        check32("multu_stall_cycles", 32'(sc), 32'd33);
        check32("multu_done_pulses", 32'(dc), 32'd1);
        check32("multu_hi", hi, 32'hFFFF_FFFE);
        check32("multu_lo", lo, 32'h0000_0001);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, sc, dc);
        check32("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check32("mult_neg_lo", lo, 32'hFFFF_FFF1);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, sc, dc);
        check32("mult_min_hi", hi, 32'h4000_0000);
        check32("mult_min_lo", lo, 32'd0);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, sc, dc);
        check32("div_neg_lo", lo, 32'hFFFF_FFFD);
        check32("div_neg_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd0, 1'b0, sc, dc);
        check32("divu_zero_lo", lo, 32'hFFFF_FFFF);
        check32("divu_zero_hi", hi, 32'd7);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, sc, dc);
        check32("div_ovf_lo", lo, 32'h8000_0000);
        check32("div_ovf_hi", hi, 32'd0);

        run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0, sc, dc);
        check32("mthi_hi", hi, 32'h1234_5678);
        check32("mthi_stall", 32'(sc), 32'd0);
        run_op(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0, sc, dc);
        check32("mtlo_lo", lo, 32'h9ABC_DEF0);
        check32("mtlo_stall", 32'(sc), 32'd0);
        run_op(3'd3, 32'd100, 32'd7, 1'b0, sc, dc);
        check32("divu_lo", lo, 32'd14);
        check32("divu_hi", hi, 32'd2);

        // Start held off by an external stall, then DONE held by an external stall.
        op_valid   = 1'b1;
        op         = 3'd2;
        src_a      = 32'hFFFF_FF9C;
        src_b      = 32'd7;
        pipe_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check32("held_start_stallreq", {31'd0, stallreq}, 32'd1);
            @(posedge clk);
            #1;
        end
        pipe_stall = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check32("held_div_done_seen", {31'd0, seen}, 32'd1);
        pipe_stall = 1'b1;
        dcount = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) pipe_stall = 1'b0;
            @(negedge clk);
            if (done) dcount++;
        end
        check32("held_done_cycles", 32'(dcount), 32'd3);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        check32("held_div_lo", lo, 32'hFFFF_FFF2);
        check32("held_div_hi", hi, 32'hFFFF_FFFE);
        @(negedge clk);
        check32("held_no_restart", {30'd0, stallreq, done}, 32'd0);

        // Reset at iteration 10 of a divide.
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op       = 3'd3;
        src_a    = 32'd1000;
        src_b    = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        rst      = 1'b1;
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        check32("abort_stall_done", {30'd0, stallreq, done}, 32'd0);
        @(posedge clk);
        #1;
        run_op(3'd1, 32'd3, 32'd4, 1'b0, sc, dc);
        check32("post_abort_lo", lo, 32'd12);
        check32("post_abort_hi", hi, 32'd0);

        for (int n = 0; n < 60; n++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b1, sc, dc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        @(negedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, instantiated inside the EX stage.
- Serves mult, multu, div, divu, mthi and mtlo using operands already forwarded by ID (rs on src_a, rt on src_b).
- Raises a stall request so IF/ID/EX hold while an iterative operation runs.
- Exports HI/LO so EX can complete mfhi/mflo.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is supported, and iteration count equals WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- op_valid  input  1  EX holds a valid muldiv-class instruction this cycle
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6-7 ignored
- src_a  input  WIDTH  rs value (multiplicand/dividend; mthi/mtlo data)
- src_b  input  WIDTH  rt value (multiplier/divisor)
- pipe_stall  input  1  EX held by a stall other than this unit's
- stallreq  output  1  hold pipeline through EX
- done  output  1  one-cycle pulse: HI/LO hold the new result
- hi  output  WIDTH  architectural HI register
- lo  output  WIDTH  architectural LO register

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, stallreq=0, done=0. Internal counters and accumulators are cleared.
- Reset mid-operation aborts the operation immediately; HI/LO become 0.
- States: IDLE, MUL, DIV, DONE.
- start condition: state==IDLE & op_valid & op in {0..3}.
- stallreq (combinational): asserted when start is true, or when state is MUL or DIV. It is 0 in IDLE without start and 0 in DONE.
- IDLE, start & !pipe_stall:
  - Latch |src_a| and |src_b| (absolute values for signed ops; raw values for unsigned).
  - Latch negate-result flag = signed & (sign_a ^ sign_b); for divide also latch the remainder sign = sign_a.
  - count=0; go to MUL (op 0/1) or DIV (op 2/3).
- IDLE, start & pipe_stall: stay IDLE and latch nothing; stallreq is still 1.
- mthi/mtlo: in IDLE with op_valid & !pipe_stall, write src_a into hi or lo at the clock edge. No stall, no done, no state change.
- MUL:
  - Radix-2 shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - After the cycle with count==WIDTH-1: {hi,lo} = product, negated in 2's complement over 64 bits if the flag is set; go to DONE.
- DIV:
  - Restoring radix-2 division, one quotient bit per cycle.
  - After the cycle with count==WIDTH-1: lo = quotient (negated if the flag is set), hi = remainder (negated if sign_a, signed ops only); go to DONE.
- Latency: the start cycle plus WIDTH iteration cycles, so stallreq is high for 33 consecutive cycles. HI/LO are visible, and done=1, in the 34th cycle (DONE).
- DONE:
  - done=1; stallreq=0, so the held instruction may leave EX.
  - If pipe_stall: stay DONE and do not restart, even though op_valid is still high; done stays 1.
  - Else: go to IDLE. The next cycle's op_valid belongs to a new instruction.
- The pipe_stall input is ignored during MUL and DIV; iteration continues.
- Divide by zero:
  - divu/div with src_b=0 produces the natural restoring result: lo=32'hFFFFFFFF, hi=|src_a|.
  - Sign fixes are then applied as above. No exception is raised.
- Signed overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Back-to-back: a muldiv op immediately following DONE starts in the IDLE cycle after DONE. HI/LO from the previous op are already valid for mfhi/mflo in that same cycle.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> stallreq high exactly 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
- mult -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 7 / 0 -> lo=0xFFFFFFFF, hi=7. Then div 0x80000000 / -1 -> lo=0x80000000, hi=0.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles -> stallreq stays 0; hi/lo update on each edge. Follow with divu 100/7 -> lo=14, hi=2.
- Start div with pipe_stall=1 for 3 cycles -> no latch and stallreq=1 during those cycles; the operation starts when pipe_stall drops. Hold pipe_stall=1 during DONE -> stays DONE, no restart, single result.
- Assert rst at iteration 10 of a div -> next cycle state IDLE, hi=lo=0, stallreq=0. A new multu 3x4 then gives lo=12, hi=0.
